// File: rtl/unified_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : unified_mem_ctrl_if
//  Brief    : Core-side request/response bus and backing-RAM port of
//             unified_mem_ctrl, bundled with controller/requester modports.
//  Revision : 1.0
// ============================================================================
interface unified_mem_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              i_fetch;
    logic [ADDR_W-1:0] i_addr;
    logic              re;
    logic              we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] wrt_data;
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] rd_data;
    logic              ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_re;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  i_fetch, i_addr, re, we, d_addr, wrt_data, mem_rdata,
        output instr, rd_data, ready, mem_addr, mem_wdata, mem_re, mem_we
    );

    modport master (
        output i_fetch, i_addr, re, we, d_addr, wrt_data, mem_rdata,
        input  instr, rd_data, ready, mem_addr, mem_wdata, mem_re, mem_we
    );
endinterface
`default_nettype wire

// File: rtl/unified_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : unified_mem_ctrl
//  Brief    : Serialises the data access and instruction fetch of one pipeline
//             advance onto a single-ported fixed-latency RAM; drives ready.
//             Optional one-entry fetch buffer enabled by macro ILINE_BUF_EN.
//  Revision : 1.0
// ============================================================================
module unified_mem_ctrl #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int MEM_LAT = 2
) (
    input  wire logic             clk,
    input  wire logic             rst,
    unified_mem_ctrl_if.slave     bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_INSTR = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] C_LAST = 4'(MEM_LAT - 1);

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic [ADDR_W-1:0] iaddr_q;
    logic              fetch_q;
    logic              re_q;
    logic [DATA_W-1:0] instr_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              mem_re_q;
    logic              mem_we_q;

    logic w_req;
    logic w_last;

    assign w_req  = bus.re | bus.we | bus.i_fetch;
    assign w_last = (cnt_q == C_LAST);

`ifdef ILINE_BUF_EN
    logic [ADDR_W-1:0] buf_tag_q;
    logic [DATA_W-1:0] buf_data_q;
    logic              buf_valid_q;
    logic              w_idle_hit;
    logic              w_data_hit;

    assign w_idle_hit = buf_valid_q && (buf_tag_q == bus.i_addr);
    // A store to the buffered address in this DATA phase kills the hit.
    assign w_data_hit = buf_valid_q && (buf_tag_q == iaddr_q) &&
                        !(mem_we_q && (mem_addr_q == buf_tag_q));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            iaddr_q     <= '0;
            fetch_q     <= 1'b0;
            re_q        <= 1'b0;
            instr_q     <= '0;
            rd_data_q   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
`ifdef ILINE_BUF_EN
            buf_tag_q   <= '0;
            buf_data_q  <= '0;
            buf_valid_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_req) begin
                        iaddr_q <= bus.i_addr;
                        fetch_q <= bus.i_fetch;
                        re_q    <= bus.re;
                        cnt_q   <= '0;
                        if (bus.re || bus.we) begin
                            state_q    <= ST_DATA;
                            mem_addr_q <= bus.d_addr;
                            mem_we_q   <= bus.we;
                            mem_re_q   <= bus.re & ~bus.we;
                            if (bus.we) begin
                                mem_wdata_q <= bus.wrt_data;
                            end
`ifdef ILINE_BUF_EN
                        end else if (w_idle_hit) begin
                            state_q <= ST_DONE;
                            instr_q <= buf_data_q;
`endif
                        end else begin
                            state_q    <= ST_INSTR;
                            mem_addr_q <= bus.i_addr;
                            mem_re_q   <= 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (!w_last) begin
                        cnt_q <= cnt_q + 4'd1;
                    end else begin
                        cnt_q    <= '0;
                        mem_we_q <= 1'b0;
                        if (re_q && mem_we_q) begin
                            rd_data_q <= '0;
                        end else if (mem_re_q) begin
                            rd_data_q <= bus.mem_rdata;
                        end
`ifdef ILINE_BUF_EN
                        if (mem_we_q && (mem_addr_q == buf_tag_q)) begin
                            buf_valid_q <= 1'b0;
                        end
                        if (fetch_q && w_data_hit) begin
                            state_q  <= ST_DONE;
                            instr_q  <= buf_data_q;
                            mem_re_q <= 1'b0;
                        end else
`endif
                        if (fetch_q) begin
                            state_q    <= ST_INSTR;
                            mem_addr_q <= iaddr_q;
                            mem_re_q   <= 1'b1;
                        end else begin
                            state_q  <= ST_DONE;
                            mem_re_q <= 1'b0;
                        end
                    end
                end
                ST_INSTR: begin
                    if (!w_last) begin
                        cnt_q <= cnt_q + 4'd1;
                    end else begin
                        cnt_q    <= '0;
                        instr_q  <= bus.mem_rdata;
                        mem_re_q <= 1'b0;
                        state_q  <= ST_DONE;
`ifdef ILINE_BUF_EN
                        buf_tag_q   <= iaddr_q;
                        buf_data_q  <= bus.mem_rdata;
                        buf_valid_q <= 1'b1;
`endif
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Idle readiness follows the live request lines so an empty advance never stalls.
    assign bus.ready     = ~rst & ((state_q == ST_DONE) |
                                   ((state_q == ST_IDLE) & ~w_req));
    assign bus.instr     = instr_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_re    = mem_re_q;
    assign bus.mem_we    = mem_we_q;

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_unified_mem_ctrl
//  Brief    : Directed self-checking bench for unified_mem_ctrl, MEM_LAT = 2.
//  Revision : 1.0
// ============================================================================
module tb_unified_mem_ctrl;
    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 16;
    localparam int MEM_LAT = 2;

    logic clk;
    logic rst;
    int   passed;
    int   total;

    logic [DATA_W-1:0] ram [0:255];

    unified_mem_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    unified_mem_ctrl #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .MEM_LAT(MEM_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backing RAM: preloaded while reset is held, written on mem_we.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) ram[i] <= '0;
            ram[8'h10] <= 16'hB123;
            ram[8'h11] <= 16'hC0DE;
            ram[8'h20] <= 16'h1111;
            ram[8'h40] <= 16'h00FF;
        end else if (bus.mem_we) begin
            ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
        end
    end

    assign bus.mem_rdata = bus.mem_re ? ram[bus.mem_addr[7:0]] : '0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic f, input logic [15:0] ia, input logic r,
                       input logic w, input logic [15:0] da, input logic [15:0] wd);
        bus.i_fetch  = f;
        bus.i_addr   = ia;
        bus.re       = r;
        bus.we       = w;
        bus.d_addr   = da;
        bus.wrt_data = wd;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst    = 1'b1;
        req(0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_instr", 32'(bus.instr), 32'h0);
        chk("rst_rd_data", 32'(bus.rd_data), 32'h0);
        chk("rst_mem_strobes", {30'd0, bus.mem_re, bus.mem_we}, 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);

        // Fetch only
        req(1, 16'h0010, 0, 0, 0, 0);
        #1 chk("f_c0_ready", 32'(bus.ready), 32'd0);
        tick(); req(0, 0, 0, 0, 0, 0);
        chk("f_c1_mem_re", 32'(bus.mem_re), 32'd1);
        chk("f_c1_mem_addr", 32'(bus.mem_addr), 32'h0010);
        chk("f_c1_ready", 32'(bus.ready), 32'd0);
        tick();
        chk("f_c2_mem_re", 32'(bus.mem_re), 32'd1);
        chk("f_c2_ready", 32'(bus.ready), 32'd0);
        tick();
        chk("f_c3_ready", 32'(bus.ready), 32'd1);
        chk("f_c3_instr", 32'(bus.instr), 32'hB123);
        chk("f_c3_mem_re", 32'(bus.mem_re), 32'd0);
        tick();

        // Load + fetch
        req(1, 16'h0011, 1, 0, 16'h0040, 0);
        tick(); req(0, 0, 0, 0, 0, 0);
        chk("lf_c1_mem_addr", 32'(bus.mem_addr), 32'h0040);
        chk("lf_c1_mem_re", 32'(bus.mem_re), 32'd1);
        tick();
        chk("lf_c2_ready", 32'(bus.ready), 32'd0);
        tick();
        chk("lf_c3_mem_addr", 32'(bus.mem_addr), 32'h0011);
        chk("lf_c3_rd_data", 32'(bus.rd_data), 32'h00FF);
        chk("lf_c3_ready", 32'(bus.ready), 32'd0);
        tick();
        chk("lf_c4_ready", 32'(bus.ready), 32'd0);
        tick();
        chk("lf_c5_ready", 32'(bus.ready), 32'd1);
        chk("lf_c5_instr", 32'(bus.instr), 32'hC0DE);
        tick();

        // Store only
        req(0, 0, 0, 1, 16'h0040, 16'hA5A5);
        tick(); req(0, 0, 0, 0, 0, 0);
        chk("st_c1_strobes", {30'd0, bus.mem_re, bus.mem_we}, 32'd1);
        chk("st_c1_wdata", 32'(bus.mem_wdata), 32'hA5A5);
        tick();
        chk("st_c2_strobes", {30'd0, bus.mem_re, bus.mem_we}, 32'd1);
        tick();
        chk("st_c3_ready", 32'(bus.ready), 32'd1);
        chk("st_c3_strobes", {30'd0, bus.mem_re, bus.mem_we}, 32'd0);
        chk("st_instr_held", 32'(bus.instr), 32'hC0DE);
        chk("st_rd_data_held", 32'(bus.rd_data), 32'h00FF);
        tick();

        // Read back the store
        req(0, 0, 1, 0, 16'h0040, 0);
        repeat (3) begin
            tick(); req(0, 0, 0, 0, 0, 0);
        end
        chk("rb_ready", 32'(bus.ready), 32'd1);
        chk("rb_rd_data", 32'(bus.rd_data), 32'hA5A5);
        tick();

        // Simultaneous re & we behaves as a write
        req(0, 0, 1, 1, 16'h0050, 16'h1234);
        tick(); req(0, 0, 0, 0, 0, 0);
        chk("rw_c1_strobes", {30'd0, bus.mem_re, bus.mem_we}, 32'd1);
        tick();
        chk("rw_c2_strobes", {30'd0, bus.mem_re, bus.mem_we}, 32'd1);
        tick();
        chk("rw_c3_ready", 32'(bus.ready), 32'd1);
        chk("rw_rd_data", 32'(bus.rd_data), 32'h0000);
        chk("rw_ram", 32'(ram[8'h50]), 32'h1234);
        tick();

        // Reset in cycle 1 of an instruction phase
        req(1, 16'h0010, 0, 0, 0, 0);
        tick(); req(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        chk("mr_instr", 32'(bus.instr), 32'h0);
        chk("mr_ready", 32'(bus.ready), 32'd0);
        chk("mr_mem_re", 32'(bus.mem_re), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("mr_idle_ready", 32'(bus.ready), 32'd1);
        repeat (3) tick();
        chk("mr_no_partial", 32'(bus.instr), 32'h0);
        chk("mr_still_idle", 32'(bus.ready), 32'd1);

`ifdef ILINE_BUF_EN
        req(1, 16'h0020, 0, 0, 0, 0);
        repeat (3) begin
            tick(); req(0, 0, 0, 0, 0, 0);
        end
        chk("bf_miss_instr", 32'(bus.instr), 32'h1111);
        tick();
        req(1, 16'h0020, 0, 0, 0, 0);
        tick(); req(0, 0, 0, 0, 0, 0);
        chk("bf_hit_ready", 32'(bus.ready), 32'd1);
        chk("bf_hit_mem_re", 32'(bus.mem_re), 32'd0);
        chk("bf_hit_instr", 32'(bus.instr), 32'h1111);
        tick();
        req(1, 16'h0020, 0, 1, 16'h0020, 16'h2222);
        repeat (3) begin
            tick(); req(0, 0, 0, 0, 0, 0);
        end
        chk("bf_inv_mem_re", 32'(bus.mem_re), 32'd1);
        chk("bf_inv_mem_addr", 32'(bus.mem_addr), 32'h0020);
        repeat (2) tick();
        chk("bf_inv_ready", 32'(bus.ready), 32'd1);
        chk("bf_inv_instr", 32'(bus.instr), 32'h2222);
        tick();
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/unified_mem_ctrl.md
Name: unified_mem_ctrl

Overview:
- Memory-side responder for the core's memory interface: serves instruction fetch (i_fetch/i_addr/instr) and data access (re/we/d_addr/wrt_data/rd_data) from a single-ported, fixed-latency backing RAM.
- Serialises the data access and the instruction fetch of one pipeline advance.
- Drives `ready`; the core freezes every pipeline register while `ready` is low.

Parameters:
- DATA_W, 16, data/instruction word width.
- ADDR_W, 16, word address width.
- MEM_LAT, 2, backing-RAM access cycles per phase. Legal values 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- i_fetch  in  1  instruction fetch request.
- i_addr  in  ADDR_W  fetch address (PC).
- re  in  1  data read request.
- we  in  1  data write request.
- d_addr  in  ADDR_W  data address.
- wrt_data  in  DATA_W  store data.
- instr  out  DATA_W  fetched instruction, registered.
- rd_data  out  DATA_W  load data, registered.
- ready  out  1  all requests of this advance are complete.
- mem_addr  out  ADDR_W  backing-RAM address.
- mem_wdata  out  DATA_W  backing-RAM write data.
- mem_re  out  1  backing-RAM read strobe.
- mem_we  out  1  backing-RAM write strobe.
- mem_rdata  in  DATA_W  backing-RAM read data, valid in the last cycle of a phase.

Behaviour:
- Reset (async, any state):
  - state goes to IDLE, phase counter to 0.
  - instr = 16'h0000 (bubble), rd_data = 0, ready = 0.
  - mem_re = mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - In-flight access is abandoned; no partial result is written to instr or rd_data.
- FSM states: IDLE, DATA, INSTR, DONE.
- IDLE:
  - ready = ~(re|we|i_fetch).
  - With any request, capture i_addr, d_addr, wrt_data and the request flags in the same cycle.
  - Go to DATA if (re|we), else to INSTR.
  - Inputs are ignored from capture until return to IDLE.
- DATA:
  - Hold mem_addr = captured d_addr for exactly MEM_LAT cycles.
  - we: mem_we = 1, mem_wdata = captured wrt_data.
  - re only: mem_re = 1; in the last cycle, sample mem_rdata into rd_data.
  - re & we together: treat as a write; rd_data is loaded with 0.
  - Exit to INSTR if i_fetch was captured, else to DONE.
- INSTR:
  - mem_re = 1, mem_addr = captured i_addr for MEM_LAT cycles.
  - Sample mem_rdata into instr in the last cycle, then go to DONE.
- DONE:
  - ready = 1 for exactly one cycle; go to IDLE.
  - instr and rd_data stay valid and stable until the next sample.
- Latency (request seen in cycle 0, ready high in cycle N):
  - fetch only: N = MEM_LAT+1.
  - data only: N = MEM_LAT+1.
  - data + fetch: N = 2*MEM_LAT+1.
- Outputs unaffected by an access are held, not cleared (e.g. a write-only advance leaves instr unchanged).
- mem_re and mem_we are never high together, and are both low in IDLE and DONE.
- Phase counter counts 0..MEM_LAT-1 and clears on every phase entry. Address arithmetic is none; addresses pass through unchanged.

Optional Feature:
- Macro: ILINE_BUF_EN.
- When defined:
  - A one-entry fetch buffer (tag = last fetched i_addr, valid bit, cleared on rst) is kept.
  - On a captured fetch with valid && tag == i_addr, the INSTR phase is skipped and instr is reloaded from the buffer. Fetch-only hit: ready at cycle 1.
  - A write whose d_addr equals the tag clears valid in its DATA phase, before the INSTR decision.
- When not defined: every fetch performs an INSTR phase; no buffer logic is present.

Test Plan:
- Reset: rst=1 mid-INSTR (cycle 1 of 2) -> immediately instr=0, ready=0, mem_re=0; after release, state is IDLE with ready=1 while no requests are present.
- Fetch, MEM_LAT=2, RAM[0x0010]=0xB123, i_fetch=1, i_addr=0x0010 -> mem_re high in cycles 1-2 with mem_addr=0x0010; ready=1 in cycle 3 only; instr=0xB123.
- Load+fetch: re=1, d_addr=0x0040 (RAM=0x00FF), i_fetch=1, i_addr=0x0011 -> data phase first (cycles 1-2), fetch in cycles 3-4; ready in cycle 5; rd_data=0x00FF.
- Store: we=1, d_addr=0x0040, wrt_data=0xA5A5, i_fetch=0 -> mem_we high 2 cycles, ready in cycle 3, instr unchanged; a subsequent read returns 0xA5A5.
- re&we simultaneous: d_addr=0x0050, wrt_data=0x1234 -> write only, mem_re never high, rd_data=0x0000.
- ILINE_BUF_EN: fetch 0x0020 twice -> second fetch ready at cycle 1, no mem_re; then store to 0x0020 plus fetch 0x0020 -> INSTR phase occurs and returns the new data.
